xulie_serializer: RTL

Parallel-to-serial source stage that feeds the serial sequence detector's `Din` input. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding register lets consecutive words stream with no gap cycles. Its `Dout` drives the detector's `Din` directly; `Dout_valid` and `Word_done` are for bench and monitor use.

---
 rtl/xulie_pkg.sv | 14 +
 rtl/xulie_prbs7.sv | 23 ++
 rtl/xulie_serializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/xulie_pkg.sv
// Shared constants and mode encoding for the xulie serializer and its PRBS7 source.
package xulie_pkg;

    localparam int         XULIE_WIDTH    = 8;
    localparam logic       XULIE_IDLE_BIT = 1'b0;

    // PRBS7, x^7 + x^6 + 1
    localparam logic [6:0] PRBS7_SEED  = 7'h7F;
    localparam int         PRBS7_TAP_A = 6;
    localparam int         PRBS7_TAP_B = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, PRBS} mode_e;

endpackage

// File: rtl/xulie_prbs7.sv
// PRBS7 generator: free-running while enabled, holds its state otherwise.
module xulie_prbs7
    import xulie_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic prbs_bit
);

    logic [6:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= PRBS7_SEED;
        end else if (en) begin
            lfsr <= {lfsr[5:0], lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B]};
        end
    end

    assign prbs_bit = lfsr[6];

endmodule

// File: rtl/xulie_serializer.sv
// Parallel-to-serial source with a one-word holding register for gapless streaming.
// Optional PRBS7 test source enabled by defining XULIE_SER_PRBS_EN.
module xulie_serializer
    import xulie_pkg::*;
#(
    parameter int   WIDTH     = XULIE_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = XULIE_IDLE_BIT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             Load_valid,
`ifdef XULIE_SER_PRBS_EN
    input  logic             Prbs_sel,
`endif
    output logic             Load_ready,
    output logic             Dout,
    output logic             Dout_valid,
    output logic             Word_done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mode_e            mode;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CW-1:0]    cnt;
    logic             active;
    logic             last;
    logic             free;
    logic             accept;
    logic             head;

    assign active     = (mode == SHIFT);
    assign last       = (cnt == LAST);
    assign free       = !active || last;
    assign Load_ready = Reset && !hold_full && (mode != PRBS);
    assign accept     = Load_valid && Load_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign head     = sr[WIDTH-1];
            assign sr_shift = {sr[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head     = sr[0];
            assign sr_shift = {1'b0, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mode      <= IDLE;
            hold_full <= 1'b0;
            cnt       <= '0;
            sr        <= '0;
            hold      <= '0;
        end else if (mode == PRBS) begin
`ifdef XULIE_SER_PRBS_EN
            if (!Prbs_sel) mode <= IDLE;
`else
            mode <= IDLE;
`endif
        end else if (free) begin
            // A held word always wins; Load_ready is low then, so nothing is lost.
            if (hold_full) begin
                sr        <= hold;
                hold_full <= 1'b0;
                cnt       <= '0;
                mode      <= SHIFT;
            end else if (accept) begin
                sr   <= Data_in;
                cnt  <= '0;
                mode <= SHIFT;
            end
`ifdef XULIE_SER_PRBS_EN
            else if (Prbs_sel) begin
                mode <= PRBS;
            end
`endif
            else begin
                mode <= IDLE;
            end
        end else begin
            cnt <= cnt + 1'b1;
            sr  <= sr_shift;
            if (accept) begin
                hold      <= Data_in;
                hold_full <= 1'b1;
            end
        end
    end

`ifdef XULIE_SER_PRBS_EN
    logic prbs_bit;

    xulie_prbs7 u_prbs (
        .clk      (Clk),
        .rst_n    (Reset),
        .en       (mode == PRBS),
        .prbs_bit (prbs_bit)
    );

    assign Dout = (mode == PRBS) ? prbs_bit : (active ? head : IDLE_BIT);
`else
    assign Dout = active ? head : IDLE_BIT;
`endif

    assign Dout_valid = (mode != IDLE);
    assign Word_done  = active && last;

endmodule
